// File: rtl/alu_result_buffer.sv
// FWFT result buffer behind the ALU: stores {op,result} pairs and hands them to a valid/ready consumer.
// Optional accept/drop statistics are enabled by defining ALU_RESULT_BUFFER_STATS_EN.
module alu_result_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [OP_W-1:0]          in_op,
  input  logic [DATA_W-1:0]        in_result,
  output logic                     in_ready,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_W-1:0]          out_op,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              total_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] result;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty;
  logic          push, pop, drop;

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign push = in_valid && !full && !clear;
  assign drop = in_valid &&  full && !clear;
  assign pop  = out_ready && !empty && !clear;

  assign in_ready  = !full;
  assign out_valid = !empty;

  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_op     = head.op;
  assign out_result = head.result;
  assign out_zero   = out_valid && (head.result == '0);

  // Storage is intentionally unreset; only pointers and flags carry state that matters.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{op: in_op, result: in_result};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef ALU_RESULT_BUFFER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_cnt <= '0;
      drop_cnt  <= '0;
    end else if (clear) begin
      total_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push && total_cnt != 16'hFFFF) total_cnt <= total_cnt + 16'd1;
      if (drop && drop_cnt  != 16'hFFFF) drop_cnt  <= drop_cnt  + 16'd1;
    end
  end
`else
  assign total_cnt = 16'd0;
  assign drop_cnt  = 16'd0;
`endif

endmodule
